// File: rtl/trng_pkg.sv
// Shared types and default parameters for the TRNG sequencing controller.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COLLECT = 2'd2,
        FAIL    = 2'd3
    } trng_state_t;

    localparam int unsigned DEF_WIDTH         = 32;
    localparam int unsigned DEF_WARMUP_CYCLES = 256;
    localparam int unsigned DEF_REP_LIMIT     = 32;

endpackage : trng_pkg

// File: rtl/trng_vn_extractor.sv
// Von Neumann extractor: pairs consecutive raw samples, emits the first bit of a 10/01 pair.
module trng_vn_extractor (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic clear,
    output logic bit_valid,
    output logic bit_val
);

    logic phase;
    logic first;

    // Pair phase and held first sample; clear keeps the phase aligned to pair start.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase <= 1'b0;
            first <= 1'b0;
        end else begin
            phase <= ~phase;
            if (!phase) begin
                first <= sample;
            end
        end
    end

    // 10 emits 1, 01 emits 0; 00 and 11 are discarded.
    always_comb begin
        bit_valid = phase & ~clear & (first ^ sample);
        bit_val   = first;
    end

endmodule : trng_vn_extractor

// File: rtl/trng_ctrl.sv
// TRNG sequencing controller: oscillator gating, warm-up, whitening, word packing, health test.
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int unsigned REP_LIMIT     = DEF_REP_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             trng_en,
    input  logic             trng_out,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             health_fail,
    output logic             busy
);

    localparam int unsigned WCW = $clog2(WARMUP_CYCLES) + 1;
    localparam int unsigned BCW = $clog2(WIDTH) + 1;
    localparam int unsigned RCW = $clog2(REP_LIMIT) + 1;

    trng_state_t      state;
    trng_state_t      state_nx;
    logic [WCW-1:0]   warm_cnt;
    logic [RCW-1:0]   rep_cnt;
    logic [RCW-1:0]   rep_nx;
    logic             prev_sample;
    logic [BCW-1:0]   bit_cnt;
    logic [BCW-1:0]   bit_cnt_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic             vn_valid;
    logic             vn_bit;
    logic             vn_clear;
    logic             collecting;
    logic             emit;
    logic             load;
    logic             xfer;
    logic             trng_en_d;
    logic             busy_d;
    logic             health_fail_d;

    assign vn_clear = (state != COLLECT);

    trng_vn_extractor u_vn (
        .clk       (clk),
        .reset     (reset),
        .sample    (trng_out),
        .clear     (vn_clear),
        .bit_valid (vn_valid),
        .bit_val   (vn_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic, including the repetition-count health test.
    always_comb begin
        state_nx = state;
        rep_nx   = RCW'(1);
        if (rep_cnt != '0 && trng_out == prev_sample) begin
            rep_nx = rep_cnt + RCW'(1);
        end
        case (state)
            IDLE: begin
                if (enable) state_nx = WARMUP;
            end
            WARMUP: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (warm_cnt == WCW'(WARMUP_CYCLES - 1)) begin
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (rep_nx == RCW'(REP_LIMIT)) begin
                    state_nx = FAIL;
                end
            end
            FAIL: begin
                if (!enable) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output and datapath next values; a word loads as soon as its last bit arrives.
    always_comb begin
        trng_en_d     = (state_nx == WARMUP) || (state_nx == COLLECT);
        busy_d        = trng_en_d;
        health_fail_d = (state_nx == FAIL);
        collecting    = (state == COLLECT) && (state_nx == COLLECT);
        emit          = vn_valid && (bit_cnt != BCW'(WIDTH));
        bit_cnt_nx    = bit_cnt;
        shreg_nx      = shreg;
        if (emit) begin
            bit_cnt_nx = bit_cnt + BCW'(1);
            shreg_nx   = (shreg << 1) | WIDTH'(vn_bit);
        end
        xfer = data_valid && data_ready;
        load = collecting && (bit_cnt_nx == BCW'(WIDTH)) && (!data_valid || data_ready);
    end

    // Counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt    <= '0;
            rep_cnt     <= '0;
            prev_sample <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            trng_en     <= 1'b0;
            busy        <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            trng_en     <= trng_en_d;
            busy        <= busy_d;
            health_fail <= health_fail_d;
            warm_cnt    <= (state == WARMUP && state_nx == WARMUP) ? warm_cnt + WCW'(1) : '0;
            if (collecting) begin
                rep_cnt     <= rep_nx;
                prev_sample <= trng_out;
            end else begin
                rep_cnt     <= '0;
                prev_sample <= 1'b0;
            end
            if (state_nx == FAIL) begin
                shreg      <= '0;
                bit_cnt    <= '0;
                data_valid <= 1'b0;
            end else if (collecting) begin
                shreg <= shreg_nx;
                if (load) begin
                    data       <= shreg_nx;
                    data_valid <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt_nx;
                    if (xfer) data_valid <= 1'b0;
                end
            end else begin
                shreg   <= '0;
                bit_cnt <= '0;
                if (xfer) data_valid <= 1'b0;
            end
        end
    end

endmodule : trng_ctrl

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl with WIDTH=8, WARMUP_CYCLES=4, REP_LIMIT=8.
module tb_trng_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             trng_en;
    logic             trng_out;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             data_ready;
    logic             health_fail;
    logic             busy;

    int checks;
    int failures;

    trng_ctrl #(
        .WIDTH         (WIDTH),
        .WARMUP_CYCLES (4),
        .REP_LIMIT     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .trng_en     (trng_en),
        .trng_out    (trng_out),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .health_fail (health_fail),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural TRNG: drive n raw bits, MSB of the pattern first, one per cycle.
    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            trng_out = bits[i];
            tick();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        trng_out   = 1'b0;
        data_ready = 1'b0;
        tick();
        tick();
        chk("rst_trng_en", 32'(trng_en), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_health", 32'(health_fail), 32'h0);
        reset = 1'b0;
        tick();
        chk("idle_trng_en", 32'(trng_en), 32'h0);

        // Warm-up timing: trng_en the cycle after enable, warm-up samples ignored.
        enable = 1'b1;
        tick();
        chk("warm_trng_en", 32'(trng_en), 32'h1);
        chk("warm_busy", 32'(busy), 32'h1);
        feed(32'b1110, 4);
        chk("warm_end_valid", 32'(data_valid), 32'h0);

        // Whitening: 10,01,11,00,10 repeated, ready high.
        data_ready = 1'b1;
        feed(32'b100111001010011100101001, 24);
        chk("white_valid", 32'(data_valid), 32'h1);
        chk("white_data", 32'(data), 32'hB6);
        feed(32'b1, 1);
        chk("white_pulse", 32'(data_valid), 32'h0);
        feed(32'b0, 1);

        // Back-pressure: second word held in the shift register, loads on accept.
        data_ready = 1'b0;
        feed(32'b01100110011001, 14);
        chk("bp_w1_valid", 32'(data_valid), 32'h1);
        chk("bp_w1_data", 32'(data), 32'hAA);
        feed(32'b1010010110100101, 16);
        chk("bp_hold_valid", 32'(data_valid), 32'h1);
        chk("bp_hold_data", 32'(data), 32'hAA);
        feed(32'b01, 2);
        chk("bp_drop_data", 32'(data), 32'hAA);
        data_ready = 1'b1;
        feed(32'b1, 1);
        chk("bp_load_valid", 32'(data_valid), 32'h1);
        chk("bp_load_data", 32'(data), 32'hCC);
        feed(32'b0, 1);
        chk("bp_after_valid", 32'(data_valid), 32'h0);

        // Disable mid-collect with a pending word and a partial word.
        data_ready = 1'b0;
        feed(32'b01011010010110, 14);
        chk("dis_pend_valid", 32'(data_valid), 32'h1);
        chk("dis_pend_data", 32'(data), 32'h99);
        feed(32'b1010, 4);
        enable = 1'b0;
        feed(32'b1, 1);
        chk("dis_trng_en", 32'(trng_en), 32'h0);
        chk("dis_busy", 32'(busy), 32'h0);
        chk("dis_keep_valid", 32'(data_valid), 32'h1);
        chk("dis_keep_data", 32'(data), 32'h99);
        data_ready = 1'b1;
        tick();
        chk("dis_read_valid", 32'(data_valid), 32'h0);
        data_ready = 1'b0;
        enable = 1'b1;
        tick();
        chk("reen_trng_en", 32'(trng_en), 32'h1);
        feed(32'b1110, 4);
        feed(32'b1001011010100110, 16);
        chk("reen_valid", 32'(data_valid), 32'h1);
        chk("reen_data", 32'(data), 32'h9D);

        // Health test: eight identical samples trip the repetition counter.
        data_ready = 1'b1;
        feed(32'b1111111, 7);
        chk("hl_pre_health", 32'(health_fail), 32'h0);
        chk("hl_pre_trng_en", 32'(trng_en), 32'h1);
        chk("hl_pre_valid", 32'(data_valid), 32'h0);
        feed(32'b1, 1);
        chk("hl_health", 32'(health_fail), 32'h1);
        chk("hl_trng_en", 32'(trng_en), 32'h0);
        chk("hl_busy", 32'(busy), 32'h0);
        feed(32'b0, 1);
        chk("hl_sticky", 32'(health_fail), 32'h1);
        enable = 1'b0;
        tick();
        chk("hl_clear", 32'(health_fail), 32'h0);
        chk("hl_idle_en", 32'(trng_en), 32'h0);

        // Reset mid-operation with a valid word pending.
        data_ready = 1'b0;
        enable = 1'b1;
        tick();
        feed(32'b0000, 4);
        feed(32'b1001100110011001, 16);
        chk("rm_valid", 32'(data_valid), 32'h1);
        chk("rm_data", 32'(data), 32'hAA);
        reset = 1'b1;
        tick();
        chk("rm_rst_valid", 32'(data_valid), 32'h0);
        chk("rm_rst_data", 32'(data), 32'h0);
        chk("rm_rst_trng_en", 32'(trng_en), 32'h0);
        chk("rm_rst_busy", 32'(busy), 32'h0);
        chk("rm_rst_health", 32'(health_fail), 32'h0);
        reset = 1'b0;
        enable = 1'b0;
        tick();
        chk("rm_idle_en", 32'(trng_en), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_trng_ctrl
